// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port index constants and the byte-mask width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  localparam logic PORT0  = 1'b0;
  localparam logic PORT1  = 1'b1;
  localparam int   MASK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [MASK_W-1:0] p0_wmask;
  logic              p0_rstrb;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;
  logic              p0_busy;

  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [MASK_W-1:0] p1_wmask;
  logic              p1_rstrb;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;
  logic              p1_busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_addr, p0_wdata, p0_wmask, p0_rstrb,
    output p0_rdata, p0_rvalid, p0_busy,
    input  p1_addr, p1_wdata, p1_wmask, p1_rstrb,
    output p1_rdata, p1_rvalid, p1_busy,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata
  );

  modport master (
    output p0_addr, p0_wdata, p0_wmask, p0_rstrb,
    input  p0_rdata, p0_rvalid, p0_busy,
    output p1_addr, p1_wdata, p1_wmask, p1_rstrb,
    input  p1_rdata, p1_rvalid, p1_busy,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_slot.sv
// One pending-request slot. A request (read strobe or nonzero write mask) is
// captured when the slot is free, or in the very cycle the slot is being
// retired, so a requester may chain a new access on its completion pulse.
// Requests arriving while the slot is busy are dropped.
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic              req_rstrb,
  input  logic              clear,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [MASK_W-1:0] wmask,
  output logic              is_read
);

  logic              pending_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              is_read_r;
  logic              is_write_s;
  logic              capture_s;

  assign is_write_s = (req_wmask != {MASK_W{1'b0}});
  assign capture_s  = (req_rstrb || is_write_s) && (!pending_r || clear);

  // Capture a new request, retire a completed one, otherwise hold.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_r <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wmask_r   <= {MASK_W{1'b0}};
      is_read_r <= 1'b0;
    end else if (capture_s) begin
      pending_r <= 1'b1;
      addr_r    <= req_addr;
      wdata_r   <= req_wdata;
      wmask_r   <= req_wmask;
      is_read_r <= !is_write_s;
    end else if (clear) begin
      pending_r <= 1'b0;
    end
  end

  assign pending = pending_r;
  assign addr    = addr_r;
  assign wdata   = wdata_r;
  assign wmask   = wmask_r;
  assign is_read = is_read_r;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (1-cycle read).
// Each access runs IDLE -> ACCESS -> RESPOND. Contention is resolved
// round-robin; defining MEM_ARB_FIXED_PRIO_EN makes port 0 always win instead.
// Read data is forwarded straight from the RAM in the completion cycle and
// held in a per-port register afterwards.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_r, state_s;
  logic              grant_r, grant_s;
  logic              last_grant_r;

  logic              pend0_s, pend1_s;
  logic [ADDR_W-1:0] addr0_s, addr1_s, sel_addr_s;
  logic [DATA_W-1:0] wdata0_s, wdata1_s, sel_wdata_s;
  logic [MASK_W-1:0] wmask0_s, wmask1_s, sel_wmask_s;
  logic              is_read0_s, is_read1_s, sel_is_read_s;
  logic              clear0_s, clear1_s;

  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [MASK_W-1:0] mem_wmask_r;
  logic              mem_rstrb_r;
  logic              rvalid0_r, rvalid1_r;
  logic [DATA_W-1:0] rdata0_r, rdata1_r;
  logic [DATA_W-1:0] rdata0_s, rdata1_s;

  assign clear0_s = (state_r == RESPOND) && (grant_r == PORT0);
  assign clear1_s = (state_r == RESPOND) && (grant_r == PORT1);

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .resetn(resetn),
    .req_addr(bus.p0_addr), .req_wdata(bus.p0_wdata),
    .req_wmask(bus.p0_wmask), .req_rstrb(bus.p0_rstrb),
    .clear(clear0_s), .pending(pend0_s), .addr(addr0_s),
    .wdata(wdata0_s), .wmask(wmask0_s), .is_read(is_read0_s)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .resetn(resetn),
    .req_addr(bus.p1_addr), .req_wdata(bus.p1_wdata),
    .req_wmask(bus.p1_wmask), .req_rstrb(bus.p1_rstrb),
    .clear(clear1_s), .pending(pend1_s), .addr(addr1_s),
    .wdata(wdata1_s), .wmask(wmask1_s), .is_read(is_read1_s)
  );

  // Next-state and grant selection; grant only changes when leaving IDLE.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (pend0_s && pend1_s) begin
          state_s = ACCESS;
`ifdef MEM_ARB_FIXED_PRIO_EN
          grant_s = PORT0;
`else
          grant_s = !last_grant_r;
`endif
        end else if (pend0_s) begin
          state_s = ACCESS;
          grant_s = PORT0;
        end else if (pend1_s) begin
          state_s = ACCESS;
          grant_s = PORT1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = RESPOND;
      RESPOND: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      grant_r      <= PORT0;
      last_grant_r <= PORT1;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      if (state_r == RESPOND) begin
        last_grant_r <= grant_r;
      end
    end
  end

  assign sel_addr_s    = grant_s ? addr1_s    : addr0_s;
  assign sel_wdata_s   = grant_s ? wdata1_s   : wdata0_s;
  assign sel_wmask_s   = grant_s ? wmask1_s   : wmask0_s;
  assign sel_is_read_s = grant_s ? is_read1_s : is_read0_s;

  // RAM port registers: loaded on entry to ACCESS, zero in every other state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_wmask_r <= {MASK_W{1'b0}};
      mem_rstrb_r <= 1'b0;
    end else if (state_s == ACCESS) begin
      mem_addr_r  <= sel_addr_s;
      mem_wdata_r <= sel_wdata_s;
      mem_wmask_r <= sel_is_read_s ? {MASK_W{1'b0}} : sel_wmask_s;
      mem_rstrb_r <= sel_is_read_s;
    end else begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_wmask_r <= {MASK_W{1'b0}};
      mem_rstrb_r <= 1'b0;
    end
  end

  // Completion pulses and held read data per port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DATA_W{1'b0}};
      rdata1_r  <= {DATA_W{1'b0}};
    end else begin
      rvalid0_r <= (state_s == RESPOND) && (grant_s == PORT0);
      rvalid1_r <= (state_s == RESPOND) && (grant_s == PORT1);
      rdata0_r  <= rdata0_s;
      rdata1_r  <= rdata1_s;
    end
  end

  // Forward RAM data during a read completion, otherwise present held data.
  always_comb begin
    rdata0_s = rdata0_r;
    rdata1_s = rdata1_r;
    if (clear0_s && is_read0_s) begin
      rdata0_s = bus.mem_rdata;
    end else begin
      rdata0_s = rdata0_r;
    end
    if (clear1_s && is_read1_s) begin
      rdata1_s = bus.mem_rdata;
    end else begin
      rdata1_s = rdata1_r;
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_wmask = mem_wmask_r;
  assign bus.mem_rstrb = mem_rstrb_r;
  assign bus.p0_rvalid = rvalid0_r;
  assign bus.p1_rvalid = rvalid1_r;
  assign bus.p0_rdata  = rdata0_s;
  assign bus.p1_rdata  = rdata1_s;
  assign bus.p0_busy   = pend0_s;
  assign bus.p1_busy   = pend1_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of isolated single-port accesses
// followed by hand-written contention, reset-abort and busy-drop sequences.
// A small byte-maskable RAM model sits on the memory port.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [31:0] last_rd [2];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 64 words, 1-cycle read latency, byte write enables.
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (bus.mem_rstrb) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_wmask[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  typedef struct {
    logic        port;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic rs, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm);
    if (p == 1'b0) begin
      bus.p0_rstrb = rs; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_wmask = wm;
    end else begin
      bus.p1_rstrb = rs; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_wmask = wm;
    end
  endtask

  function automatic logic get_rvalid(input logic p);
    return p ? bus.p1_rvalid : bus.p0_rvalid;
  endfunction

  function automatic logic get_busy(input logic p);
    return p ? bus.p1_busy : bus.p0_busy;
  endfunction

  function automatic logic [31:0] get_rdata(input logic p);
    return p ? bus.p1_rdata : bus.p0_rdata;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    resetn = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  task automatic mem_idle_check(input string tag);
    check({tag, " mem_addr"}, bus.mem_addr, 32'h0);
    check({tag, " mem_rstrb"}, {31'h0, bus.mem_rstrb}, 32'h0);
    check({tag, " mem_wmask"}, {28'h0, bus.mem_wmask}, 32'h0);
  endtask

  // One uncontended access: issued in cycle T, checked at T+1..T+4.
  task automatic do_txn(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    drive(v.port, !v.is_wr, v.addr, v.wdata, v.is_wr ? v.wmask : 4'h0);
    tick();
    drive(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
    check({t, " busy T+1"}, {31'h0, get_busy(v.port)}, 32'h1);
    tick();
    check({t, " mem_addr"}, bus.mem_addr, v.addr);
    check({t, " mem_rstrb"}, {31'h0, bus.mem_rstrb}, {31'h0, !v.is_wr});
    check({t, " mem_wmask"}, {28'h0, bus.mem_wmask}, {28'h0, v.is_wr ? v.wmask : 4'h0});
    if (v.is_wr) check({t, " mem_wdata"}, bus.mem_wdata, v.wdata);
    tick();
    check({t, " rvalid T+3"}, {31'h0, get_rvalid(v.port)}, 32'h1);
    check({t, " other rvalid"}, {31'h0, get_rvalid(!v.port)}, 32'h0);
    check({t, " rdata"}, get_rdata(v.port), v.is_wr ? last_rd[v.port] : v.exp_rdata);
    mem_idle_check({t, " T+3"});
    tick();
    check({t, " rvalid T+4"}, {31'h0, get_rvalid(v.port)}, 32'h0);
    check({t, " busy T+4"}, {31'h0, get_busy(v.port)}, 32'h0);
    if (!v.is_wr) last_rd[v.port] = v.exp_rdata;
  endtask

  initial begin
    logic first;
    logic exp_port;
    checks = 0;
    errors = 0;

    //          port  wr    addr      wdata         wmask  expected read
    vecs[0]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h20, 32'h12345678, 4'h3, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h20, 32'h0,        4'h0, 32'hAABB5678};
    vecs[5]  = '{1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h24, 32'h11223344, 4'hC, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h24, 32'h0,        4'h0, 32'h1122F00D};
    vecs[8]  = '{1'b1, 1'b1, 32'h28, 32'h00000000, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h28, 32'hA1B2C3D4, 4'h5, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h28, 32'h0,        4'h0, 32'h00B200D4};

    // Reset state.
    do_reset();
    check("reset p0_busy", {31'h0, bus.p0_busy}, 32'h0);
    check("reset p1_busy", {31'h0, bus.p1_busy}, 32'h0);
    check("reset p0_rvalid", {31'h0, bus.p0_rvalid}, 32'h0);
    check("reset p1_rvalid", {31'h0, bus.p1_rvalid}, 32'h0);
    check("reset p0_rdata", bus.p0_rdata, 32'h0);
    check("reset p1_rdata", bus.p1_rdata, 32'h0);
    mem_idle_check("reset");

    // Table of isolated accesses.
    for (int i = 0; i < 11; i++) do_txn(vecs[i], i);

    // Simultaneous reads after reset: port 0 wins first.
    do_reset();
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    check("both1 p0_rvalid T+3", {31'h0, bus.p0_rvalid}, 32'h1);
    check("both1 p1_rvalid T+3", {31'h0, bus.p1_rvalid}, 32'h0);
    check("both1 p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    check("both1 p1_busy T+3", {31'h0, bus.p1_busy}, 32'h1);
    tick();
    tick();
    tick();
    check("both1 p1_rvalid T+6", {31'h0, bus.p1_rvalid}, 32'h1);
    check("both1 p1_rdata", bus.p1_rdata, 32'hAABB5678);
    tick();

    // A lone port-0 access leaves port 0 as last grant; the next contended
    // pair then goes to port 1 first (fixed priority: port 0 first).
    do_txn(vecs[1], 101);
`ifdef MEM_ARB_FIXED_PRIO_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    check("both2 first rvalid", {31'h0, get_rvalid(first)}, 32'h1);
    check("both2 second idle", {31'h0, get_rvalid(!first)}, 32'h0);
    tick();
    tick();
    tick();
    check("both2 second rvalid", {31'h0, get_rvalid(!first)}, 32'h1);
    check("both2 first quiet", {31'h0, get_rvalid(first)}, 32'h0);
    tick();

    // Port 0 chains a read on each of its completions while port 1 keeps
    // requesting: grants alternate (fixed priority: port 0 every time).
    do_reset();
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_port = 1'b0;
`else
      exp_port = k[0];
`endif
      check($sformatf("rr win%0d p0_rvalid", k), {31'h0, bus.p0_rvalid}, {31'h0, !exp_port});
      check($sformatf("rr win%0d p1_rvalid", k), {31'h0, bus.p1_rvalid}, {31'h0, exp_port});
      drive(1'b0, !exp_port, 32'h10, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset pulse during ACCESS aborts silently.
    do_reset();
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("abort in ACCESS", {31'h0, bus.mem_rstrb}, 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort p0_rvalid", {31'h0, bus.p0_rvalid}, 32'h0);
    check("abort p0_busy", {31'h0, bus.p0_busy}, 32'h0);
    check("abort p1_busy", {31'h0, bus.p1_busy}, 32'h0);
    check("abort p0_rdata", bus.p0_rdata, 32'h0);
    mem_idle_check("abort");
    tick();
    check("abort p0_rvalid later", {31'h0, bus.p0_rvalid}, 32'h0);
    do_txn(vecs[7].port ? '{1'b0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h1122F00D} : vecs[7], 200);

    // Second strobe while busy is dropped.
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b1, 32'h28, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("drop mem_addr", bus.mem_addr, 32'h10);
    tick();
    check("drop p0_rvalid", {31'h0, bus.p0_rvalid}, 32'h1);
    check("drop p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    tick();
    check("drop p0_busy", {31'h0, bus.p0_busy}, 32'h0);
    tick();
    check("drop no 2nd access", {31'h0, bus.mem_rstrb}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
